// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: assigns note-on events to voices (stealing when full) and routes note-offs.
// in_event = {status(1=ON), note[6:0], velocity[6:0]}; optional sustain pedal via VOICE_ALLOC_SUSTAIN_EN.
module midi_voice_allocator #(
    parameter  int NUM_VOICES = 8,
    localparam int VIDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef VOICE_ALLOC_SUSTAIN_EN
    input  logic                    sustain_hold,
`endif
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [14:0]             in_event,
    input  logic [NUM_VOICES-1:0]   env_idle,
    output logic [NUM_VOICES-1:0]   voice_gate,
    output logic [NUM_VOICES-1:0]   voice_trigger,
    output logic [NUM_VOICES*7-1:0] voice_note,
    output logic [NUM_VOICES*7-1:0] voice_velocity,
    output logic                    steal_pulse
);

    typedef enum logic [1:0] {
        V_FREE      = 2'd0,
        V_HELD      = 2'd1,
        V_RELEASING = 2'd2,
        V_SUSTAINED = 2'd3
    } vstate_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_UPDATE = 2'd2
    } fsm_t;

    localparam logic [NUM_VOICES-1:0] ONE_V = {{(NUM_VOICES-1){1'b0}}, 1'b1};

    fsm_t                    fsm_r, fsm_s;
    logic                    in_ready_s;
    logic                    ev_on_r;
    logic [6:0]              ev_note_r, ev_vel_r;
    logic [NUM_VOICES-1:0]   sel_r, sel_s;
    logic                    steal_sel_r, steal_s;
    vstate_t                 vstate_r [NUM_VOICES];
    logic [6:0]              note_r   [NUM_VOICES];
    logic [6:0]              vel_r    [NUM_VOICES];
    logic [VIDX_W-1:0]       age_r    [NUM_VOICES];
    logic [NUM_VOICES*VIDX_W-1:0] age_flat_s;
    logic [VIDX_W-1:0]       old_age_s;
    logic [NUM_VOICES-1:0]   match_s, free_s, rel_s, held_s;
    logic [NUM_VOICES-1:0]   gate_r, trig_r;
    logic                    steal_r;

    // Isolate the lowest set bit of a mask.
    function automatic logic [NUM_VOICES-1:0] lowest_one(input logic [NUM_VOICES-1:0] m);
        return m & (~m + ONE_V);
    endfunction

    // One-hot of the masked voice with the largest age (ages are distinct).
    function automatic logic [NUM_VOICES-1:0] oldest_one(input logic [NUM_VOICES-1:0] m,
                                                         input logic [NUM_VOICES*VIDX_W-1:0] ages);
        logic [NUM_VOICES-1:0] r;
        logic [VIDX_W-1:0]     best;
        logic                  found;
        r     = '0;
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (m[i] && (!found || ages[i*VIDX_W +: VIDX_W] > best)) begin
                r     = ONE_V << i;
                best  = ages[i*VIDX_W +: VIDX_W];
                found = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

`ifdef VOICE_ALLOC_SUSTAIN_EN
    logic                  sus_d_r, sus_q_r, sus_fall_s;
    logic [NUM_VOICES-1:0] sus_s;

    // Pedal sampling for release-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sus_d_r <= 1'b0;
            sus_q_r <= 1'b0;
        end else begin
            sus_d_r <= sustain_hold;
            sus_q_r <= sus_d_r;
        end
    end

    assign sus_fall_s = sus_q_r & ~sus_d_r;
`endif

    // Control FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_r <= S_IDLE;
        end else begin
            fsm_r <= fsm_s;
        end
    end

    // Control FSM next state and handshake.
    always_comb begin
        fsm_s      = fsm_r;
        in_ready_s = 1'b0;
        case (fsm_r)
            S_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    fsm_s = S_LOOKUP;
                end else begin
                    fsm_s = S_IDLE;
                end
            end
            S_LOOKUP: fsm_s = S_UPDATE;
            S_UPDATE: fsm_s = S_IDLE;
            default:  fsm_s = S_IDLE;
        endcase
    end

    assign in_ready = in_ready_s;

    // Event latch; velocity 0 on a note-on is folded into note-off here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_on_r   <= 1'b0;
            ev_note_r <= 7'd0;
            ev_vel_r  <= 7'd0;
        end else if (fsm_r == S_IDLE && in_valid) begin
            ev_on_r   <= in_event[14] && (in_event[6:0] != 7'd0);
            ev_note_r <= in_event[13:7];
            ev_vel_r  <= in_event[6:0];
        end
    end

    // Classification vectors, match and voice selection.
    always_comb begin
        match_s    = '0;
        free_s     = '0;
        rel_s      = '0;
        held_s     = '0;
        age_flat_s = '0;
`ifdef VOICE_ALLOC_SUSTAIN_EN
        sus_s      = '0;
`endif
        for (int i = 0; i < NUM_VOICES; i++) begin
            free_s[i] = (vstate_r[i] == V_FREE);
            rel_s[i]  = (vstate_r[i] == V_RELEASING);
            held_s[i] = (vstate_r[i] == V_HELD);
`ifdef VOICE_ALLOC_SUSTAIN_EN
            sus_s[i]  = (vstate_r[i] == V_SUSTAINED);
`endif
            match_s[i] = (note_r[i] == ev_note_r) &&
                         (ev_on_r ? (vstate_r[i] != V_FREE) : (vstate_r[i] == V_HELD));
            age_flat_s[i*VIDX_W +: VIDX_W] = age_r[i];
        end
        steal_s = 1'b0;
        if (!ev_on_r || (|match_s)) begin
            sel_s = lowest_one(match_s);
        end else if (|free_s) begin
            sel_s = lowest_one(free_s);
        end else if (|rel_s) begin
            sel_s = oldest_one(rel_s, age_flat_s);
`ifdef VOICE_ALLOC_SUSTAIN_EN
        end else if (|sus_s) begin
            sel_s   = oldest_one(sus_s, age_flat_s);
            steal_s = 1'b1;
`endif
        end else begin
            sel_s   = oldest_one(held_s, age_flat_s);
            steal_s = 1'b1;
        end
    end

    // Selection register, captured in LOOKUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r       <= '0;
            steal_sel_r <= 1'b0;
        end else if (fsm_r == S_LOOKUP) begin
            sel_r       <= sel_s;
            steal_sel_r <= steal_s;
        end
    end

    // Age of the voice being written, for the recency shuffle.
    always_comb begin
        old_age_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            old_age_s = old_age_s | (sel_r[i] ? age_r[i] : '0);
        end
    end

    // Voice table and pulse outputs; UPDATE is applied last so it overrides env_idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                vstate_r[i] <= V_FREE;
                note_r[i]   <= 7'd0;
                vel_r[i]    <= 7'd0;
                age_r[i]    <= VIDX_W'(NUM_VOICES - 1 - i);
            end
            gate_r  <= '0;
            trig_r  <= '0;
            steal_r <= 1'b0;
        end else begin
            trig_r  <= '0;
            steal_r <= (fsm_r == S_UPDATE) && ev_on_r && steal_sel_r;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (vstate_r[i] == V_RELEASING && env_idle[i]) begin
                    vstate_r[i] <= V_FREE;
                end
`ifdef VOICE_ALLOC_SUSTAIN_EN
                if (sus_fall_s && vstate_r[i] == V_SUSTAINED) begin
                    vstate_r[i] <= V_RELEASING;
                    gate_r[i]   <= 1'b0;
                end
`endif
                if (fsm_r == S_UPDATE && ev_on_r) begin
                    if (sel_r[i]) begin
                        vstate_r[i] <= V_HELD;
                        note_r[i]   <= ev_note_r;
                        vel_r[i]    <= ev_vel_r;
                        age_r[i]    <= '0;
                        gate_r[i]   <= 1'b1;
                        trig_r[i]   <= 1'b1;
                    end else if (age_r[i] < old_age_s) begin
                        age_r[i] <= age_r[i] + VIDX_W'(1);
                    end
                end else if (fsm_r == S_UPDATE && sel_r[i]) begin
`ifdef VOICE_ALLOC_SUSTAIN_EN
                    if (sustain_hold) begin
                        vstate_r[i] <= V_SUSTAINED;
                    end else begin
                        vstate_r[i] <= V_RELEASING;
                        gate_r[i]   <= 1'b0;
                    end
`else
                    vstate_r[i] <= V_RELEASING;
                    gate_r[i]   <= 1'b0;
`endif
                end
            end
        end
    end

    // Flatten per-voice note/velocity onto the output buses.
    always_comb begin
        voice_note     = '0;
        voice_velocity = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_note[i*7 +: 7]     = note_r[i];
            voice_velocity[i*7 +: 7] = vel_r[i];
        end
    end

    assign voice_gate    = gate_r;
    assign voice_trigger = trig_r;
    assign steal_pulse   = steal_r;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Self-checking bench for midi_voice_allocator (default build): directed plan plus randomized events
// against a recency-list reference model.
module tb_midi_voice_allocator;
    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [14:0]    in_event;
    logic [N-1:0]   env_idle;
    logic [N-1:0]   voice_gate, voice_trigger;
    logic [N*7-1:0] voice_note, voice_velocity;
    logic           steal_pulse;

    midi_voice_allocator #(.NUM_VOICES(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_event(in_event),
        .env_idle(env_idle), .voice_gate(voice_gate), .voice_trigger(voice_trigger),
        .voice_note(voice_note), .voice_velocity(voice_velocity), .steal_pulse(steal_pulse)
    );

    always #5 clk = ~clk;

    // Reference model: 0 free, 1 held, 2 releasing; order holds voices most-recently-triggered first.
    int           mstate [N];
    int           mnote  [N];
    int           mvel   [N];
    int           order  [$];
    logic [N-1:0] exp_trig;
    logic         exp_steal;
    int           checks = 0;
    int           errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] m_gate();
        logic [N-1:0] g = '0;
        for (int i = 0; i < N; i++) g[i] = (mstate[i] == 1);
        return g;
    endfunction

    function automatic logic [N*7-1:0] m_bus(input bit want_vel);
        logic [N*7-1:0] b = '0;
        for (int i = 0; i < N; i++) b[i*7 +: 7] = 7'(want_vel ? mvel[i] : mnote[i]);
        return b;
    endfunction

    task automatic model_reset();
        order = {};
        for (int i = 0; i < N; i++) begin
            mstate[i] = 0; mnote[i] = 0; mvel[i] = 0;
        end
        for (int i = N - 1; i >= 0; i--) order.push_back(i);
    endtask

    task automatic model_event(input bit on, input int note, input int vel);
        int v = -1;
        exp_trig  = '0;
        exp_steal = 1'b0;
        if (on && vel != 0) begin
            for (int i = 0; i < N; i++) if (mstate[i] != 0 && mnote[i] == note) v = i;
            for (int i = 0; i < N; i++) if (v < 0 && mstate[i] == 0) v = i;
            for (int k = order.size() - 1; k >= 0; k--) if (v < 0 && mstate[order[k]] == 2) v = order[k];
            if (v < 0) begin
                v = order[order.size() - 1];
                exp_steal = 1'b1;
            end
            mstate[v] = 1; mnote[v] = note; mvel[v] = vel;
            exp_trig[v] = 1'b1;
            for (int k = 0; k < order.size(); k++) if (order[k] == v) begin order.delete(k); break; end
            order.push_front(v);
        end else begin
            for (int i = 0; i < N; i++) if (mstate[i] == 1 && mnote[i] == note) mstate[i] = 2;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_gate"}, voice_gate, m_gate());
        chk({tag, "_note"}, voice_note, m_bus(1'b0));
        chk({tag, "_vel"}, voice_velocity, m_bus(1'b1));
    endtask

    task automatic send(input bit on, input int note, input int vel);
        @(negedge clk);
        chk("ready_idle", in_ready, 1'b1);
        in_valid = 1'b1;
        in_event = {on, 7'(note), 7'(vel)};
        @(negedge clk);
        in_valid = 1'b0;
        chk("ready_lookup", in_ready, 1'b0);
        @(negedge clk);
        chk("ready_update", in_ready, 1'b0);
        chk("trig_early", voice_trigger, '0);
        model_event(on, note, vel);
        @(negedge clk);
        chk("ready_back", in_ready, 1'b1);
        chk("trigger", voice_trigger, exp_trig);
        chk("steal", steal_pulse, exp_steal);
        check_outputs("ev");
        @(negedge clk);
        chk("trig_clear", voice_trigger, '0);
        chk("steal_clear", steal_pulse, 1'b0);
    endtask

    task automatic env_pulse(input logic [N-1:0] m);
        @(negedge clk);
        env_idle = m;
        @(negedge clk);
        env_idle = '0;
        for (int i = 0; i < N; i++) if (m[i] && mstate[i] == 2) mstate[i] = 0;
        chk("env_gate", voice_gate, m_gate());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_event = '0;
        env_idle = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_gate", voice_gate, '0);
        chk("rst_trig", voice_trigger, '0);
        chk("rst_steal", steal_pulse, 1'b0);
        chk("rst_note", voice_note, '0);
        rst_n = 1'b1;

        // First note lands in voice 0.
        send(1'b1, 60, 100);
        chk("first_note", voice_note[6:0], 7'd60);
        chk("first_gate", voice_gate, 8'h01);

        // Release a middle note, free it, re-fill lowest free voice.
        do_reset();
        send(1'b1, 60, 100); send(1'b1, 62, 100); send(1'b1, 64, 100);
        send(1'b0, 62, 0);
        chk("off62_gate", voice_gate, 8'h05);
        env_pulse(8'h02);
        send(1'b1, 65, 80);
        chk("on65_gate", voice_gate, 8'h07);
        chk("on65_note", voice_note[13:7], 7'd65);

        // Steal oldest held voice, then stale note-off does nothing.
        do_reset();
        for (int n = 60; n < 68; n++) send(1'b1, n, 64);
        send(1'b1, 70, 50);
        chk("steal_note0", voice_note[6:0], 7'd70);
        send(1'b0, 60, 0);
        chk("stale_off_gate", voice_gate, 8'hFF);

        // Releasing voices preferred over stealing; older releasing voice wins.
        do_reset();
        for (int n = 60; n < 68; n++) send(1'b1, n, 64);
        send(1'b0, 61, 0); send(1'b0, 63, 0);
        send(1'b1, 72, 33);
        chk("rel_pick_note1", voice_note[13:7], 7'd72);
        chk("rel_pick_gate", voice_gate, 8'hF7);

        // Retrigger and velocity-0 note-off.
        do_reset();
        send(1'b1, 60, 100);
        send(1'b1, 60, 90);
        chk("retrig_vel", voice_velocity[6:0], 7'd90);
        chk("retrig_gate", voice_gate, 8'h01);
        send(1'b1, 60, 0);
        chk("vel0_gate", voice_gate, 8'h00);
        send(1'b1, 60, 20);
        chk("retrig_rel_gate", voice_gate, 8'h01);

        // Reset asserted while in LOOKUP.
        do_reset();
        send(1'b1, 50, 10);
        @(negedge clk);
        in_valid = 1'b1;
        in_event = {1'b1, 7'd51, 7'd11};
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_gate", voice_gate, '0);
        chk("midrst_note", voice_note, '0);
        chk("midrst_trig", voice_trigger, '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("midrst_ready", in_ready, 1'b1);
        repeat (3) @(negedge clk);
        chk("midrst_no_pulse", voice_trigger, '0);
        check_outputs("midrst");

        // Randomized traffic over a narrow note range to force matches and steals.
        do_reset();
        for (int it = 0; it < 300; it++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) send(1'b1, int'($urandom_range(60, 73)), (r == 0) ? 0 : int'($urandom_range(1, 127)));
            else if (r < 9) send(1'b0, int'($urandom_range(60, 73)), int'($urandom_range(0, 127)));
            else env_pulse(N'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
